// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: state encoding, slice width and preload helper shared by
// the ls161 timer controller files.
package timer_ctrl_pkg;

   localparam int unsigned SLICE_W = 4;
   localparam int unsigned MAX_W   = 64;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_FIN
   } state_t;

   // Negation: the low WIDTH bits equal (2^WIDTH - p) mod 2^WIDTH for any WIDTH <= MAX_W.
   function automatic logic [MAX_W-1:0] preload(input logic [MAX_W-1:0] p);
      return '0 - p;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: 4-bit cyclic down-counter (reload..0) with a zero flag.
// Only compiled when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic [3:0] reload,
   output logic       zero
);

   logic [3:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == '0) ? reload : count - 4'd1;
      end
   end

   assign zero = (count == '0);

endmodule
`endif

// File: rtl/ls161_timer_ctrl.sv
// ls161_timer_ctrl: sequences a chain of 161-style counter slices as a one-shot
// or periodic timer. Define TIMER_PRESCALE_EN to add the PRESCALE input.
module ls161_timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             STOP,
   input  logic             MODE,
   input  logic [WIDTH-1:0] PERIOD,
`ifdef TIMER_PRESCALE_EN
   input  logic [3:0]       PRESCALE,
`endif
   input  logic [WIDTH-1:0] CNT_Q,
   input  logic             CNT_RCO,
   output logic             CLR_n,
   output logic             LOAD_n,
   output logic             ENP,
   output logic             ENT,
   output logic [WIDTH-1:0] D,
   output logic             BUSY,
   output logic             TICK,
   output logic             DONE
);

   if ((WIDTH % SLICE_W) != 0 || WIDTH > MAX_W || WIDTH == 0) begin : g_bad_width
      $error("ls161_timer_ctrl: WIDTH must be a non-zero multiple of 4, at most 64");
   end

   state_t           state;
   state_t           state_next;
   logic             mode_q;
   logic [WIDTH-1:0] d_q;
   logic             tick_q;
   logic             enp_raw;
   logic             term;
   logic             capture;

`ifdef TIMER_PRESCALE_EN
   logic [3:0] prescale_q;
   logic       pre_zero;

   always_ff @(posedge CLK) begin
      if (RST) begin
         prescale_q <= '0;
      end else if (capture) begin
         prescale_q <= PRESCALE;
      end
   end

   timer_prescaler u_prescaler (
      .clk    (CLK),
      .rst    (RST),
      .clear  (state == ST_LOAD),
      .enable (state == ST_RUN),
      .reload (prescale_q),
      .zero   (pre_zero)
   );

   assign enp_raw = pre_zero;
`else
   assign enp_raw = 1'b1;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_next;
      end
   end

   // Terminal uses the ungated enable so the one-shot hold on ENP cannot mask it.
   always_comb begin
      state_next = state;
      CLR_n      = 1'b1;
      LOAD_n     = 1'b1;
      ENP        = 1'b0;
      ENT        = 1'b0;
      DONE       = 1'b0;
      term       = 1'b0;
      case (state)
         ST_CLEAR: begin
            CLR_n      = 1'b0;
            state_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (STOP) begin
               state_next = ST_CLEAR;
            end else if (START && PERIOD != '0) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            LOAD_n     = 1'b0;
            state_next = STOP ? ST_CLEAR : ST_RUN;
         end
         ST_RUN: begin
            ENT  = 1'b1;
            term = CNT_RCO & enp_raw;
            if (mode_q) begin
               ENP    = enp_raw;
               LOAD_n = ~term;
            end else begin
               ENP = enp_raw & ~CNT_RCO;
            end
            if (STOP) begin
               state_next = ST_CLEAR;
            end else if (term && !mode_q) begin
               state_next = ST_FIN;
            end
         end
         ST_FIN: begin
            DONE       = ~STOP;
            state_next = STOP ? ST_CLEAR : ST_IDLE;
         end
         default: state_next = ST_CLEAR;
      endcase
   end

   assign capture = (state == ST_IDLE) && (state_next == ST_LOAD);

   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_q <= 1'b0;
         d_q    <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= (state == ST_RUN) && term && !STOP;
         if (capture) begin
            mode_q <= MODE;
            d_q    <= WIDTH'(preload(MAX_W'(PERIOD)));
         end
      end
   end

   assign D    = d_q;
   assign TICK = tick_q;
   assign BUSY = (state == ST_LOAD) || (state == ST_RUN);

   // The chain's terminal count must agree with its observed value while running.
   a_rco_matches_q: assert property (@(posedge CLK) disable iff (RST)
      (state == ST_RUN) |-> (CNT_RCO == &CNT_Q));

endmodule

// File: tb/tb_ls161_timer_ctrl.sv
// tb_ls161_timer_ctrl: randomized self-checking bench driving an 8-bit 161
// counter chain model from the controller (TIMER_PRESCALE_EN optional).
module tb_ls161_timer_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         mode = 1'b0;
   logic [W-1:0] period = '0;
   logic [3:0]   prescale = '0;
   logic [W-1:0] cnt_q = '0;
   logic         cnt_rco;
   logic         clr_n, load_n, enp, ent, busy, tick, done;
   logic [W-1:0] d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // counter chain: sync clear, sync load, count when ENP & ENT, RCO = all ones
   always @(posedge clk) begin
      if (!clr_n)              cnt_q <= '0;
      else if (!load_n)        cnt_q <= d;
      else if (enp && ent)     cnt_q <= cnt_q + W'(1);
   end
   assign cnt_rco = &cnt_q;

   ls161_timer_ctrl #(.WIDTH(W)) dut (
      .CLK      (clk),
      .RST      (rst),
      .START    (start),
      .STOP     (stop),
      .MODE     (mode),
      .PERIOD   (period),
`ifdef TIMER_PRESCALE_EN
      .PRESCALE (prescale),
`endif
      .CNT_Q    (cnt_q),
      .CNT_RCO  (cnt_rco),
      .CLR_n    (clr_n),
      .LOAD_n   (load_n),
      .ENP      (enp),
      .ENT      (ent),
      .D        (d),
      .BUSY     (busy),
      .TICK     (tick),
      .DONE     (done)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; period = '0; prescale = '0;
      for (int i = 0; i < 2; i++) begin
         step;
         checks++;
         if ({clr_n, load_n, enp, ent, busy, tick, done} !== 7'b0100000 || d !== '0) begin
            errors++;
            $display("FAIL reset_outputs edge=%0d: got ctl=%b d=%h required ctl=0100000 d=00",
                     i, {clr_n, load_n, enp, ent, busy, tick, done}, d);
         end
      end
      rst = 1'b0;
      checks++;
      if (clr_n !== 1'b0) begin
         errors++;
         $display("FAIL reset_clear_after: got CLR_n=%b required 0", clr_n);
      end
      step;
      checks++;
      if ({clr_n, load_n, enp, ent, busy, tick, done} !== 7'b1100000 || d !== '0 || cnt_q !== '0) begin
         errors++;
         $display("FAIL reset_idle: got ctl=%b d=%h q=%h required ctl=1100000 d=00 q=00",
                  {clr_n, load_n, enp, ent, busy, tick, done}, d, cnt_q);
      end
   endtask

   task automatic test_oneshot(input int p);
      logic [W-1:0] dexp;
      logic [W-1:0] exp_q;
      logic         exp_enp;
      dexp   = W'((1 << W) - p);
      period = W'(p); mode = 1'b0; start = 1'b1;
      step;
      start  = 1'b0; period = W'($urandom); mode = 1'($urandom);
      checks++;
      if (load_n !== 1'b0 || busy !== 1'b1 || d !== dexp) begin
         errors++;
         $display("FAIL oneshot_load p=%0d: got LOAD_n=%b BUSY=%b D=%h required 0 1 %h",
                  p, load_n, busy, d, dexp);
      end
      step;
      for (int k = 0; k <= p + 1; k++) begin
         exp_q   = (k < p) ? W'(int'(dexp) + k) : '1;
         exp_enp = (k < p - 1);
         checks++;
         if (cnt_q !== exp_q || enp !== exp_enp) begin
            errors++;
            $display("FAIL oneshot_count p=%0d k=%0d: got q=%h ENP=%b required q=%h ENP=%b",
                     p, k, cnt_q, enp, exp_q, exp_enp);
         end
         checks++;
         if (done !== (k == p) || tick !== (k == p) || busy !== (k < p)) begin
            errors++;
            $display("FAIL oneshot_flags p=%0d k=%0d: got DONE=%b TICK=%b BUSY=%b required %b %b %b",
                     p, k, done, tick, busy, k == p, k == p, k < p);
         end
         // START while busy must be ignored
         start  = (k < p) ? 1'($urandom) : 1'b0;
         period = W'($urandom_range(1, 255));
         step;
      end
      start = 1'b0;
   endtask

   task automatic test_periodic(input int p, input int s, input int n);
      logic [W-1:0] dexp;
      logic [W-1:0] exp_q;
      logic         exp_enp;
      logic         exp_tick;
      int           e;
      dexp     = W'((1 << W) - p);
      period   = W'(p); mode = 1'b1; prescale = 4'(s); start = 1'b1;
      step;
      start    = 1'b0; period = W'($urandom); mode = 1'($urandom); prescale = 4'($urandom);
      checks++;
      if (load_n !== 1'b0 || d !== dexp) begin
         errors++;
         $display("FAIL periodic_load p=%0d: got LOAD_n=%b D=%h required 0 %h", p, load_n, d, dexp);
      end
      step;
      for (int k = 0; k < n; k++) begin
         e        = (k + s) / (s + 1);
         exp_q    = W'(int'(dexp) + (e % p));
         exp_enp  = (k % (s + 1)) == 0;
         exp_tick = (k >= 1) && (((k - 1) % (s + 1)) == 0) && ((((k - 1 + s) / (s + 1)) % p) == p - 1);
         checks++;
         if (cnt_q !== exp_q || tick !== exp_tick) begin
            errors++;
            $display("FAIL periodic_count p=%0d s=%0d k=%0d: got q=%h TICK=%b required q=%h TICK=%b",
                     p, s, k, cnt_q, tick, exp_q, exp_tick);
         end
         checks++;
         if (enp !== exp_enp || ent !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL periodic_ctl p=%0d k=%0d: got ENP=%b ENT=%b BUSY=%b DONE=%b required %b 1 1 0",
                     p, k, enp, ent, busy, done, exp_enp);
         end
         start  = 1'($urandom);
         period = W'($urandom_range(1, 255));
         mode   = 1'($urandom);
         if (k == n - 1) stop = 1'b1;
         step;
      end
      start = 1'b0;
      checks++;
      if (clr_n !== 1'b0 || tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL periodic_stop: got CLR_n=%b TICK=%b DONE=%b BUSY=%b required 0 0 0 0",
                  clr_n, tick, done, busy);
      end
      stop = 1'b0;
      step;
      checks++;
      if (clr_n !== 1'b1 || cnt_q !== '0 || busy !== 1'b0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL periodic_after_stop: got CLR_n=%b q=%h BUSY=%b TICK=%b required 1 00 0 0",
                  clr_n, cnt_q, busy, tick);
      end
   endtask

   task automatic test_period_zero;
      period = '0; start = 1'b1; mode = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
         step;
         checks++;
         if (busy !== 1'b0 || load_n !== 1'b1 || clr_n !== 1'b1) begin
            errors++;
            $display("FAIL period_zero i=%0d: got BUSY=%b LOAD_n=%b CLR_n=%b required 0 1 1",
                     i, busy, load_n, clr_n);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_start_stop_same;
      period = W'(4); start = 1'b1; stop = 1'b1; mode = 1'b0;
      step;
      start = 1'b0; stop = 1'b0;
      checks++;
      if (clr_n !== 1'b0 || busy !== 1'b0 || load_n !== 1'b1) begin
         errors++;
         $display("FAIL start_stop_clear: got CLR_n=%b BUSY=%b LOAD_n=%b required 0 0 1",
                  clr_n, busy, load_n);
      end
      step;
      checks++;
      if (clr_n !== 1'b1 || busy !== 1'b0 || load_n !== 1'b1) begin
         errors++;
         $display("FAIL start_stop_idle: got CLR_n=%b BUSY=%b LOAD_n=%b required 1 0 1",
                  clr_n, busy, load_n);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 6; i++) begin
         test_oneshot($urandom_range(1, 20));
         test_periodic($urandom_range(1, 12), 0, $urandom_range(5, 40));
      end
   endtask

   initial begin
      test_reset;
      test_oneshot(5);
      test_periodic(3, 0, 10);
      test_periodic(1, 0, 6);
      test_oneshot(1);
      test_period_zero;
      test_start_stop_same;
      test_back_to_back;
`ifdef TIMER_PRESCALE_EN
      test_periodic(2, 2, 20);
      for (int i = 0; i < 4; i++) begin
         test_periodic($urandom_range(1, 6), $urandom_range(0, 15), $urandom_range(10, 60));
      end
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
